powlib_bus_responder: RTL and testbench

- Bus target that sits on one read port of a powlib_buscross instance and is the consuming end of that protocol.
- Accepts address/data beats, decodes them against its own address window, and services WRITE and READ operations on a local word memory.
- For each READ it issues a response beat, itself a WRITE, on an output bus that feeds a buscross write port back to the requester.

---
 rtl/powlib_bus_pkg.sv | 14 +
 rtl/powlib_bus_responder_mem.sv | 24 ++
 rtl/powlib_bus_responder.sv | 113 +++++++++++
 tb/tb_powlib_bus_responder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/powlib_bus_pkg.sv
// Shared encodings for the powlib bus: op field layout and responder FSM states.
package powlib_bus_pkg;

    localparam int OPW = 2;

    localparam logic [OPW-1:0] OP_WRITE = 2'd0;
    localparam logic [OPW-1:0] OP_READ  = 2'd1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

endpackage

// File: rtl/powlib_bus_responder_mem.sv
// Single-port word RAM with a registered read; contents are not reset.
// Read data reflects the location addressed at the previous edge (read-before-write).
module powlib_bus_responder_mem #(
    parameter int DEPTH = 256,
    parameter int DW    = 30,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata <= mem_q[addr];
    end

endmodule

// File: rtl/powlib_bus_responder.sv
// Bus target: decodes an address window, services WRITE/READ on local memory, returns READ data as a WRITE beat.
// READ accepted at edge N gives outvld in cycle N+1; requests stall (inrdy=0) while a response waits on outrdy.
module powlib_bus_responder
    import powlib_bus_pkg::*;
#(
    parameter int          B_AW = 32,
    parameter int          B_DW = 32,
    parameter int unsigned BASE = 0,
    parameter int unsigned SIZE = 256,
    parameter int          EW   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [B_DW-1:0] indata,
    input  logic [B_AW-1:0] inaddr,
    input  logic            invld,
    output logic            inrdy,
    output logic [B_DW-1:0] outdata,
    output logic [B_AW-1:0] outaddr,
    output logic            outvld,
    input  logic            outrdy,
    output logic [EW-1:0]   errcnt
);

    localparam int PW  = B_DW - OPW;
    localparam int IW  = $clog2(SIZE);
    localparam int AW1 = B_AW + 1;

    // One extra bit keeps BASE+SIZE from wrapping at the top of the address space.
    localparam logic [AW1-1:0] WIN_LO = AW1'(BASE);
    localparam logic [AW1-1:0] WIN_HI = AW1'(BASE) + AW1'(SIZE);

    state_t          state_q;
    logic            up_q;
    logic [B_AW-1:0] ret_q;
    logic [IW-1:0]   idx_q;
    logic [EW-1:0]   err_q;
    logic [EW-1:0]   err_d;

    logic [OPW-1:0]  op;
    logic [PW-1:0]   payload;
    logic            hit;
    logic [IW-1:0]   idx;
    logic [B_AW-1:0] ret;
    logic            accept;
    logic            wr_en;
    logic            rd_go;
    logic            drop;
    logic [IW-1:0]   mem_addr;
    logic [PW-1:0]   mem_rdata;

    assign op      = indata[B_DW-1 -: OPW];
    assign payload = indata[PW-1:0];
    assign hit     = ({1'b0, inaddr} >= WIN_LO) && ({1'b0, inaddr} < WIN_HI);
    assign idx     = IW'(inaddr - B_AW'(BASE));
    assign ret     = B_AW'(payload);

    assign accept = invld && inrdy;
    assign wr_en  = accept && hit && (op == OP_WRITE);
    assign rd_go  = accept && hit && (op == OP_READ);
    assign drop   = accept && !(wr_en || rd_go);
    assign err_d  = (drop && (err_q != {EW{1'b1}})) ? err_q + EW'(1) : err_q;

    // Holding the captured index while responding keeps the RAM output steady under backpressure.
    assign mem_addr = (state_q == ST_RESP) ? idx_q : idx;

    powlib_bus_responder_mem #(
        .DEPTH (SIZE),
        .DW    (PW),
        .AW    (IW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .addr  (mem_addr),
        .wdata (payload),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            up_q    <= 1'b0;
            ret_q   <= '0;
            idx_q   <= '0;
            err_q   <= '0;
        end else begin
            up_q  <= 1'b1;
            err_q <= err_d;
            case (state_q)
                ST_IDLE: begin
                    if (rd_go) begin
                        ret_q   <= ret;
                        idx_q   <= idx;
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (outrdy) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign inrdy   = up_q && (state_q == ST_IDLE);
    assign outvld  = (state_q == ST_RESP);
    assign outaddr = outvld ? ret_q : '0;
    assign outdata = outvld ? {{OPW{1'b0}}, mem_rdata} : '0;
    assign errcnt  = err_q;

endmodule

// File: tb/tb_powlib_bus_responder.sv
// Directed bench for powlib_bus_responder: window decode, read turnaround, backpressure, drops and reset.
module tb_powlib_bus_responder;

    localparam int          AW   = 32;
    localparam int          DW   = 32;
    localparam int unsigned BASE = 32'h100;
    localparam int unsigned SIZE = 256;
    localparam int          EW   = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] indata = '0;
    logic [AW-1:0] inaddr = '0;
    logic          invld = 1'b0;
    logic          inrdy;
    logic [DW-1:0] outdata;
    logic [AW-1:0] outaddr;
    logic          outvld;
    logic          outrdy = 1'b1;
    logic [EW-1:0] errcnt;

    int checks = 0;
    int errors = 0;

    powlib_bus_responder #(
        .B_AW (AW),
        .B_DW (DW),
        .BASE (BASE),
        .SIZE (SIZE),
        .EW   (EW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .indata  (indata),
        .inaddr  (inaddr),
        .invld   (invld),
        .inrdy   (inrdy),
        .outdata (outdata),
        .outaddr (outaddr),
        .outvld  (outvld),
        .outrdy  (outrdy),
        .errcnt  (errcnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents one beat and returns 1 ns after the edge it transferred on.
    task automatic send(input logic [1:0] op, input logic [31:0] addr, input logic [29:0] pl,
                        output int waited);
        indata = {op, pl};
        inaddr = addr;
        invld  = 1'b1;
        waited = 0;
        while (!inrdy && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!inrdy) begin
            check("send_timeout", 64'd0, 64'd1);
        end else begin
            @(posedge clk);
        end
        #1;
        invld = 1'b0;
    endtask

    // READ with outrdy high: response visible the cycle after acceptance, gone one cycle later.
    task automatic do_read(input string tag, input logic [31:0] addr, input logic [29:0] ret,
                           input logic [31:0] exp_data);
        int w;
        outrdy = 1'b1;
        send(2'd1, addr, ret, w);
        check({tag, "_vld"}, 64'(outvld), 64'd1);
        check({tag, "_addr"}, 64'(outaddr), 64'(ret));
        check({tag, "_data"}, 64'(outdata), 64'(exp_data));
        @(posedge clk); #1;
        check({tag, "_done"}, 64'(outvld), 64'd0);
    endtask

    initial begin
        int w;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;

        // Reset and idle
        repeat (2) @(posedge clk);
        #1;
        check("rst_outvld", 64'(outvld), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_inrdy", 64'(inrdy), 64'd1);
        check("rst_outvld2", 64'(outvld), 64'd0);
        check("rst_errcnt", 64'(errcnt), 64'd0);
        check("rst_outdata", 64'(outdata), 64'd0);
        check("rst_outaddr", 64'(outaddr), 64'd0);

        // Write then read back
        send(2'd0, BASE + 5, 30'hABC, w);
        do_read("rd5", BASE + 5, 30'h40, 32'h0000_0ABC);

        // Back-to-back writes to indices 0..3 must not stall
        for (int i = 0; i < 4; i++) begin
            send(2'd0, BASE + i, 30'h111 * (i + 1), w);
            check("b2b_nostall", 64'(w), 64'd0);
        end
        do_read("rd2", BASE + 2, 30'h80, 32'h0000_0333);
        do_read("rd0", BASE + 0, 30'h84, 32'h0000_0111);

        // Window top word is a hit
        send(2'd0, BASE + SIZE - 1, 30'h3FFF_FFFF, w);
        do_read("rdtop", BASE + SIZE - 1, 30'h3FFF_0000, 32'h3FFF_FFFF);
        check("top_noerr", 64'(errcnt), 64'd0);

        // Held response under backpressure
        outrdy = 1'b0;
        send(2'd1, BASE + 1, 30'h1234, w);
        for (int i = 0; i < 10; i++) begin
            check("stall_vld", 64'(outvld), 64'd1);
            check("stall_addr", 64'(outaddr), 64'h1234);
            check("stall_data", 64'(outdata), 64'h222);
            check("stall_inrdy", 64'(inrdy), 64'd0);
            @(posedge clk); #1;
        end
        indata = {2'd0, 30'h5A5};
        inaddr = BASE + 9;
        invld  = 1'b1;
        @(posedge clk); #1;
        check("stall_wr_inrdy", 64'(inrdy), 64'd0);
        outrdy = 1'b1;
        @(posedge clk); #1;
        check("stall_release_vld", 64'(outvld), 64'd0);
        check("stall_release_inrdy", 64'(inrdy), 64'd1);
        @(posedge clk); #1;
        invld = 1'b0;
        do_read("rd9", BASE + 9, 30'h99, 32'h0000_05A5);

        // Drops: above window, below window, reserved op on a hit
        send(2'd0, BASE + 7, 30'h777, w);
        send(2'd0, BASE + SIZE, 30'hBAD, w);
        check("drop_hi_novld", 64'(outvld), 64'd0);
        send(2'd1, BASE - 1, 30'h55, w);
        check("drop_lo_novld", 64'(outvld), 64'd0);
        send(2'd3, BASE + 7, 30'hDEAD, w);
        check("drop_op3_novld", 64'(outvld), 64'd0);
        check("drop_errcnt3", 64'(errcnt), 64'd3);
        do_read("rd7", BASE + 7, 30'h70, 32'h0000_0777);
        do_read("rd0_alias", BASE + 0, 30'h71, 32'h0000_0111);
        send(2'd2, BASE + 7, 30'h1, w);
        check("drop_errcnt4", 64'(errcnt), 64'd4);

        // Reset in the middle of a response
        outrdy = 1'b0;
        send(2'd1, BASE + 3, 30'h300, w);
        check("mid_vld", 64'(outvld), 64'd1);
        #3;
        rst = 1'b0;
        #1;
        check("mid_rst_vld", 64'(outvld), 64'd0);
        check("mid_rst_data", 64'(outdata), 64'd0);
        check("mid_rst_addr", 64'(outaddr), 64'd0);
        check("mid_rst_err", 64'(errcnt), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_inrdy", 64'(inrdy), 64'd1);
        check("post_rst_vld", 64'(outvld), 64'd0);
        check("post_rst_err", 64'(errcnt), 64'd0);
        send(2'd0, BASE + 20, 30'h2020, w);
        do_read("rd20", BASE + 20, 30'h200, 32'h0000_2020);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
